// File: rtl/heatmap_pkg.sv
// Shared definitions for the heatmap renderer: iterator state encoding,
// default VGA row pitch and the blue-to-red RGB332 palette.
package heatmap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MAP     = 3'd3,
    PRESENT = 3'd4,
    ADVANCE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int SCREEN_W_DEFAULT = 640;

  // RGB332 = {R[2:0], G[2:0], B[1:0]}; index 0 is coldest, 15 hottest.
  localparam logic [7:0] PALETTE [16] = '{
    8'h03, 8'h07, 8'h0B, 8'h0F, 8'h13, 8'h17, 8'h1B, 8'h1C,
    8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hE8, 8'hE0
  };

endpackage

// File: rtl/heat_colour_map.sv
// Combinational temperature -> palette index -> RGB332 colour.
// Also used by the legend overlay, so it carries no state.
module heat_colour_map
  import heatmap_pkg::*;
#(
  parameter logic [15:0] T_MIN     = 16'd0,
  parameter int          IDX_SHIFT = 8
) (
  input  logic [15:0] temp,
  output logic [7:0]  colour
);

  logic [16:0] diff;
  logic [15:0] steps;
  logic [3:0]  idx;

  // Bit 16 of the widened subtract flags temperatures below T_MIN.
  always_comb begin
    diff  = {1'b0, temp} - {1'b0, T_MIN};
    steps = diff[15:0] >> IDX_SHIFT;
    if (diff[16])
      idx = 4'd0;
    else if (steps > 16'd15)
      idx = 4'd15;
    else
      idx = steps[3:0];
    colour = PALETTE[idx];
  end

endmodule

// File: rtl/heatmap_col_iterator.sv
// Walks the owned screen columns top-to-bottom, fetches the grid temperature per
// pixel and offers {address, colour} to the VGA pixel arbiter on a ready/ack handshake.
module heatmap_col_iterator
  import heatmap_pkg::*;
#(
  parameter int          X_START   = 0,
  parameter int          X_END     = 639,
  parameter int          X_STEP    = 1,
  parameter int          ROWS      = 480,
  parameter int          SCREEN_W  = SCREEN_W_DEFAULT,
  parameter int          CELL_LOG2 = 3,
  parameter int          GRID_W    = 80,
  parameter logic [15:0] T_MIN     = 16'd0,
  parameter int          IDX_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] temp_addr,
  input  logic [15:0] temp_data,
  output logic        pixel_ready,
  input  logic        pixel_ack,
  output logic [31:0] vga_addr,
  output logic [31:0] vga_pxl_clr,
  output logic        col_done
);

  localparam logic [15:0] X_FIRST  = 16'(X_START);
  localparam logic [16:0] X_LAST   = 17'(X_END);
  localparam logic [16:0] X_STRIDE = 17'(X_STEP);
  localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
  localparam logic [31:0] PITCH    = 32'(SCREEN_W);
  localparam logic [15:0] GRID_PITCH = 16'(GRID_W);

  state_t      state, state_next;
  logic [15:0] x, y;
  logic [31:0] row_base;
  logic [7:0]  colour_q;
  logic [7:0]  map_colour;
  logic [16:0] x_next_col;
  logic [15:0] cell_addr;
  logic        last_row;
  logic        last_pixel;

  heat_colour_map #(
    .T_MIN     (T_MIN),
    .IDX_SHIFT (IDX_SHIFT)
  ) u_colour_map (
    .temp   (temp_data),
    .colour (map_colour)
  );

  assign x_next_col = {1'b0, x} + X_STRIDE;
  assign last_row   = (y == LAST_ROW);
  assign last_pixel = last_row && (x_next_col > X_LAST);
  assign cell_addr  = (y >> CELL_LOG2) * GRID_PITCH + (x >> CELL_LOG2);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Start overrides everything, including a same-cycle ack in PRESENT.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RD_REQ;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RD_REQ:  state_next = RD_WAIT;
        RD_WAIT: state_next = MAP;
        MAP:     state_next = PRESENT;
        PRESENT: if (pixel_ack) state_next = ADVANCE;
        ADVANCE: state_next = last_pixel ? DONE : RD_REQ;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pixel_ready = (state == PRESENT);
    col_done    = (state == DONE);
    vga_pxl_clr = {24'b0, colour_q};
  end

  // row_base tracks y*SCREEN_W by accumulation so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= X_FIRST;
      y         <= 16'd0;
      row_base  <= 32'd0;
      temp_addr <= 16'd0;
      vga_addr  <= 32'd0;
      colour_q  <= 8'd0;
    end else if (start) begin
      x        <= X_FIRST;
      y        <= 16'd0;
      row_base <= 32'd0;
    end else begin
      case (state)
        RD_REQ: temp_addr <= cell_addr;
        MAP: begin
          colour_q <= map_colour;
          vga_addr <= row_base + {16'b0, x};
        end
        ADVANCE: begin
          if (last_row) begin
            y        <= 16'd0;
            row_base <= 32'd0;
            x        <= x_next_col[15:0];
          end else begin
            y        <= y + 16'd1;
            row_base <= row_base + PITCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heatmap_col_iterator.sv
// Scoreboard bench for heatmap_col_iterator: a single-column instance (A) for
// handshake, colour and restart behaviour, and a strided instance (B) for column walking.
module tb_heatmap_col_iterator;

  localparam logic [15:0] TMIN_A = 16'h0100;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  clr;
    logic [15:0] taddr;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  logic start_a, ack_a, start_b, ack_b;
  logic [15:0] temp_addr_a, temp_data_a, temp_addr_b, temp_data_b;
  logic ready_a, ready_b, done_a, done_b;
  logic [31:0] addr_a, clr_a, addr_b, clr_b;
  logic [15:0] temp_val_a;

  pix_t sb_q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  heatmap_col_iterator #(
    .X_START(5), .X_END(5), .X_STEP(1), .ROWS(4),
    .T_MIN(TMIN_A), .IDX_SHIFT(8)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .temp_addr(temp_addr_a), .temp_data(temp_data_a),
    .pixel_ready(ready_a), .pixel_ack(ack_a),
    .vga_addr(addr_a), .vga_pxl_clr(clr_a), .col_done(done_a)
  );

  heatmap_col_iterator #(
    .X_START(1), .X_END(5), .X_STEP(2), .ROWS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .temp_addr(temp_addr_b), .temp_data(temp_data_b),
    .pixel_ready(ready_b), .pixel_ack(ack_b),
    .vga_addr(addr_b), .vga_pxl_clr(clr_b), .col_done(done_b)
  );

  // One-cycle-latency grid memory models.
  always @(posedge clk) begin
    temp_data_a <= temp_val_a;
    temp_data_b <= temp_addr_b + 16'h0A00;
  end

  function automatic logic [7:0] expColour(input logic [15:0] t, input logic [15:0] tmin);
    logic [7:0] pal [16];
    int d;
    int idx;
    pal = '{8'h03, 8'h07, 8'h0B, 8'h0F, 8'h13, 8'h17, 8'h1B, 8'h1C,
            8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hE8, 8'hE0};
    if (t < tmin) idx = 0;
    else begin
      d = (int'(t) - int'(tmin)) / 256;
      idx = (d > 15) ? 15 : d;
    end
    return pal[idx];
  endfunction

  function automatic logic curReady(input int s);
    return (s != 0) ? ready_b : ready_a;
  endfunction

  function automatic logic curDone(input int s);
    return (s != 0) ? done_b : done_a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pushPixel(input int x, input int y, input logic [15:0] t, input logic [15:0] tmin);
    pix_t p;
    p.addr  = 32'(y * 640 + x);
    p.clr   = expColour(t, tmin);
    p.taddr = 16'((y / 8) * 80 + (x / 8));
    sb_q.push_back(p);
  endtask

  task automatic setStart(input int s, input logic v);
    if (s != 0) start_b = v; else start_a = v;
  endtask

  task automatic setAck(input int s, input logic v);
    if (s != 0) ack_b = v; else ack_a = v;
  endtask

  task automatic applyStimulus(input int s);
    setStart(s, 1'b1);
    @(negedge clk);
    setStart(s, 1'b0);
  endtask

  task automatic waitReady(input int s);
    int n;
    n = 0;
    while (!curReady(s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!curReady(s)) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic comparePixel(input int s);
    pix_t p;
    if (sb_q.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
    end else begin
      p = sb_q.pop_front();
      checkOutput("vga_addr",    (s != 0) ? addr_b : addr_a, p.addr);
      checkOutput("vga_pxl_clr", (s != 0) ? clr_b : clr_a, {24'b0, p.clr});
      checkOutput("temp_addr",   {16'b0, (s != 0) ? temp_addr_b : temp_addr_a}, {16'b0, p.taddr});
    end
  endtask

  task automatic ackPixel(input int s, input int len);
    int extra;
    setAck(s, 1'b1);
    @(negedge clk);
    checkOutput("ready_fall", {31'b0, curReady(s)}, 32'd0);
    extra = 0;
    repeat (len - 1) begin
      @(negedge clk);
      if (curReady(s)) extra++;
    end
    setAck(s, 1'b0);
    if (len > 1) checkOutput("ready_during_hold", 32'(extra), 32'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_ready_a", {31'b0, ready_a}, 32'd0);
    checkOutput("rst_done_a",  {31'b0, done_a}, 32'd0);
    checkOutput("rst_addr_a",  addr_a, 32'd0);
    checkOutput("rst_clr_a",   clr_a, 32'd0);
    checkOutput("rst_taddr_a", {16'b0, temp_addr_a}, 32'd0);
    checkOutput("rst_ready_b", {31'b0, ready_b}, 32'd0);
    checkOutput("rst_done_b",  {31'b0, done_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] temps2 [4];
    logic [15:0] temps4 [3];
    int n;
    temps2 = '{16'h00FF, 16'h0800, 16'hFFFF, 16'h0350};
    temps4 = '{16'h0400, 16'h0C00, 16'h1100};

    reset = 1'b1;
    start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    temp_val_a = 16'h0000;
    repeat (3) @(negedge clk);
    checkReset();
    reset = 1'b0;
    @(negedge clk);

    // Reset held 3 cycles while a pixel is being presented.
    temp_val_a = 16'h0800;
    applyStimulus(0);
    waitReady(0);
    checkOutput("t1_ready_pre_reset", {31'b0, ready_a}, 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkReset();
    reset = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (ready_a || done_a) n++;
    end
    checkOutput("t1_quiet_after_reset", 32'(n), 32'd0);

    // Single column x=5, four rows, one ack per pixel; colour boundaries.
    sb_q.delete();
    for (int k = 0; k < 4; k++) pushPixel(5, k, temps2[k], TMIN_A);
    temp_val_a = temps2[0];
    applyStimulus(0);
    for (int k = 0; k < 4; k++) begin
      waitReady(0);
      comparePixel(0);
      checkOutput("t2_done_low", {31'b0, done_a}, 32'd0);
      @(negedge clk);
      if (k < 3) temp_val_a = temps2[k + 1];
      ackPixel(0, 1);
    end
    checkOutput("t2_done_in_advance", {31'b0, done_a}, 32'd0);
    @(negedge clk);
    checkOutput("t2_col_done", {31'b0, done_a}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t2_col_done_level", {31'b0, done_a}, 32'd1);
    checkOutput("t2_ready_in_done", {31'b0, ready_a}, 32'd0);
    checkOutput("t2_sb_drained", 32'(sb_q.size()), 32'd0);

    // Restart from DONE; ack held 4 cycles consumes exactly one pixel.
    sb_q.delete();
    for (int k = 0; k < 3; k++) pushPixel(5, k, temps4[k], TMIN_A);
    temp_val_a = temps4[0];
    applyStimulus(0);
    checkOutput("t4_done_cleared", {31'b0, done_a}, 32'd0);
    waitReady(0);
    comparePixel(0);
    temp_val_a = temps4[1];
    ackPixel(0, 4);
    waitReady(0);
    comparePixel(0);
    temp_val_a = temps4[2];
    @(negedge clk);
    ackPixel(0, 1);
    waitReady(0);
    comparePixel(0);

    // Start and ack together at pixel (5,2): start wins, frame restarts.
    sb_q.delete();
    pushPixel(5, 0, 16'h0200, TMIN_A);
    temp_val_a = 16'h0200;
    start_a = 1'b1;
    ack_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ack_a = 1'b0;
    checkOutput("t5_ready_cleared", {31'b0, ready_a}, 32'd0);
    checkOutput("t5_done_low", {31'b0, done_a}, 32'd0);
    waitReady(0);
    comparePixel(0);
    checkOutput("t5_done_still_low", {31'b0, done_a}, 32'd0);

    // Strided columns 1,3,5 with two rows each.
    sb_q.delete();
    for (int xi = 1; xi <= 5; xi += 2)
      for (int yi = 0; yi < 2; yi++)
        pushPixel(xi, yi, 16'h0A00 + 16'(((yi / 8) * 80) + (xi / 8)), 16'h0000);
    applyStimulus(1);
    for (int k = 0; k < 6; k++) begin
      waitReady(1);
      comparePixel(1);
      checkOutput("t6_done_low", {31'b0, curDone(1)}, 32'd0);
      @(negedge clk);
      ackPixel(1, 1);
    end
    @(negedge clk);
    checkOutput("t6_col_done", {31'b0, done_b}, 32'd1);
    checkOutput("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
